// File: rtl/gtxe2_chnl_rx_oob.sv
// Receive-side SATA out-of-band detector for the GTXE2 channel model.
// Measures burst and gap lengths of the electrical-idle indication. Reports a
// completed COMINIT/COMRESET or COMWAKE sequence as a one-cycle pulse.
module gtxe2_chnl_rx_oob #(
    parameter int          BURST_MIN          = 12,
    parameter int          BURST_MAX          = 20,
    parameter int          WAKE_IDLE_MIN      = 12,
    parameter int          WAKE_IDLE_MAX      = 20,
    parameter int          INIT_IDLE_MIN      = 40,
    parameter int          INIT_IDLE_MAX      = 56,
    parameter logic [3:0]  SATA_BURST_SEQ_LEN = 4'b0100
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_idle,
    output logic RXELECIDLE,
    output logic RXCOMINITDET,
    output logic RXCOMWAKEDET
);

    // A sequence of fewer than two bursts has no gap to classify, so 0 and 1 act as 2.
    localparam logic [3:0] REQ = (SATA_BURST_SEQ_LEN < 4'd2) ? 4'd2 : SATA_BURST_SEQ_LEN;

    localparam logic [7:0] B_MIN  = 8'(BURST_MIN);
    localparam logic [7:0] B_MAX  = 8'(BURST_MAX);
    localparam logic [7:0] W_MIN  = 8'(WAKE_IDLE_MIN);
    localparam logic [7:0] W_MAX  = 8'(WAKE_IDLE_MAX);
    localparam logic [7:0] I_MIN  = 8'(INIT_IDLE_MIN);
    localparam logic [7:0] I_MAX  = 8'(INIT_IDLE_MAX);

    typedef enum logic [1:0] {S_LEAD, S_BURST, S_GAP} state_t;
    typedef enum logic [1:0] {CLS_NONE, CLS_INIT, CLS_WAKE} cls_t;

    state_t     state_q, state_d;
    cls_t       cls_q, cls_d;
    cls_t       gap_cls;
    logic [7:0] burst_q, burst_d;
    logic [7:0] gap_q, gap_d;
    logic [3:0] nb_q, nb_d;
    logic [3:0] nb_inc;
    logic       init_d, wake_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign nb_inc = nb_q + 4'd1;

    // Next-state, counter and detect-pulse logic.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        state_d = state_q;
        cls_d   = cls_q;
        burst_d = burst_q;
        gap_d   = gap_q;
        nb_d    = nb_q;
        init_d  = 1'b0;
        wake_d  = 1'b0;
        gap_cls = CLS_NONE;
        case (state_q)
            S_LEAD: begin
                // The leading gap carries no class information.
                if (!rx_idle) begin
                    state_d = S_BURST;
                    burst_d = 8'd1;
                end
            end
            S_BURST: begin
                if (!rx_idle) begin
                    burst_d = sat_inc(burst_q);
                end else if (burst_q < B_MIN || burst_q > B_MAX) begin
                    nb_d    = 4'd0;
                    cls_d   = CLS_NONE;
                    state_d = S_LEAD;
                end else if (nb_inc >= REQ) begin
                    init_d  = (cls_q == CLS_INIT);
                    wake_d  = (cls_q == CLS_WAKE);
                    nb_d    = 4'd0;
                    cls_d   = CLS_NONE;
                    state_d = S_LEAD;
                end else begin
                    nb_d    = nb_inc;
                    gap_d   = 8'd1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (rx_idle) begin
                    // Longer than the largest window: no class can match any more.
                    if (gap_q >= I_MAX) begin
                        nb_d    = 4'd0;
                        cls_d   = CLS_NONE;
                        state_d = S_LEAD;
                    end else begin
                        gap_d = sat_inc(gap_q);
                    end
                end else begin
                    if (gap_q >= W_MIN && gap_q <= W_MAX)
                        gap_cls = CLS_WAKE;
                    else if (gap_q >= I_MIN && gap_q <= I_MAX)
                        gap_cls = CLS_INIT;
                    // This active sample always opens a new burst.
                    state_d = S_BURST;
                    burst_d = 8'd1;
                    if (gap_cls == CLS_NONE) begin
                        nb_d  = 4'd0;
                        cls_d = CLS_NONE;
                    end else begin
                        // A class change restarts counting with the burst just seen.
                        if (cls_q != CLS_NONE && cls_q != gap_cls)
                            nb_d = 4'd1;
                        cls_d = gap_cls;
                    end
                end
            end
            default: state_d = S_LEAD;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q      <= S_LEAD;
            cls_q        <= CLS_NONE;
            burst_q      <= 8'd0;
            gap_q        <= 8'd0;
            nb_q         <= 4'd0;
            RXELECIDLE   <= 1'b1;
            RXCOMINITDET <= 1'b0;
            RXCOMWAKEDET <= 1'b0;
        end else begin
            state_q      <= state_d;
            cls_q        <= cls_d;
            burst_q      <= burst_d;
            gap_q        <= gap_d;
            nb_q         <= nb_d;
            RXELECIDLE   <= rx_idle;
            RXCOMINITDET <= init_d;
            RXCOMWAKEDET <= wake_d;
        end
    end

endmodule

// File: tb/tb_gtxe2_chnl_rx_oob.sv
// Directed testbench for gtxe2_chnl_rx_oob: OOB burst/gap patterns with
// hand-computed detect counts and pulse cycles.
module tb_gtxe2_chnl_rx_oob;

    logic clk;
    logic reset;
    logic rx_idle;
    logic RXELECIDLE;
    logic RXCOMINITDET;
    logic RXCOMWAKEDET;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int init_cnt, wake_cnt, init_cyc, wake_cyc;
    int mark;

    gtxe2_chnl_rx_oob dut (
        .clk          (clk),
        .reset        (reset),
        .rx_idle      (rx_idle),
        .RXELECIDLE   (RXELECIDLE),
        .RXCOMINITDET (RXCOMINITDET),
        .RXCOMWAKEDET (RXCOMWAKEDET)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock with rx_idle held; outputs are sampled on the falling edge.
    task automatic step(input logic idle);
        logic exp_ei;
        rx_idle = idle;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        exp_ei = reset ? 1'b1 : idle;
        check("elecidle", RXELECIDLE, exp_ei);
        check("det_overlap", RXCOMINITDET & RXCOMWAKEDET, 0);
        if (reset) begin
            check("init_in_reset", RXCOMINITDET, 0);
            check("wake_in_reset", RXCOMWAKEDET, 0);
        end
        if (RXCOMINITDET === 1'b1) begin init_cnt++; init_cyc = cyc; end
        if (RXCOMWAKEDET === 1'b1) begin wake_cnt++; wake_cyc = cyc; end
    endtask

    task automatic burst(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    task automatic send(input int b, input int g);
        burst(b);
        gap(g);
    endtask

    task automatic clear_det();
        init_cnt = 0; wake_cnt = 0; init_cyc = -1; wake_cyc = -1;
    endtask

    // Pulse counts are in high cycles, so a count of 1 also proves single-cycle width.
    task automatic expect_det(input string tag, input int ei, input int ew, input int exp_cyc);
        check({tag, "_init_cnt"}, init_cnt, ei);
        check({tag, "_wake_cnt"}, wake_cnt, ew);
        if (ei == 1) check({tag, "_init_cyc"}, init_cyc, exp_cyc);
        if (ew == 1) check({tag, "_wake_cyc"}, wake_cyc, exp_cyc);
    endtask

    initial begin
        reset   = 1'b1;
        rx_idle = 1'b1;
        clear_det();

        // Reset held with the line idle, then RXELECIDLE tracks rx_idle one cycle late.
        gap(5);
        reset = 1'b0;
        step(1'b1); step(1'b0); step(1'b0); step(1'b1); step(1'b0); step(1'b1);
        gap(70);
        expect_det("reset", 0, 0, 0);

        // COMINIT: 4 x (16 active, 48 idle).
        clear_det();
        gap(10);
        for (int k = 0; k < 3; k++) send(16, 48);
        burst(16); mark = cyc;
        gap(70);
        expect_det("cominit", 1, 0, mark + 1);

        // COMWAKE: 4 x (16 active, 16 idle).
        clear_det();
        for (int k = 0; k < 3; k++) send(16, 16);
        burst(16); mark = cyc;
        gap(70);
        expect_det("comwake", 0, 1, mark + 1);

        // Overlong second burst aborts; the next four valid bursts detect once.
        clear_det();
        send(16, 48);
        burst(24);
        gap(48);
        for (int k = 0; k < 3; k++) send(16, 48);
        burst(16); mark = cyc;
        gap(70);
        expect_det("long_burst", 1, 0, mark + 1);

        // A 60-cycle gap aborts, leaving only three valid bursts.
        clear_det();
        send(16, 60);
        send(16, 48); send(16, 48);
        burst(16);
        gap(70);
        expect_det("gap60", 0, 0, 0);

        // Inclusive boundaries: bursts 12/20, init gaps 40/56.
        clear_det();
        send(12, 40); send(20, 56); send(12, 40);
        burst(20); mark = cyc;
        gap(70);
        expect_det("init_bounds", 1, 0, mark + 1);

        // Inclusive boundaries: wake gaps 12/20.
        clear_det();
        send(12, 12); send(20, 20); send(12, 12);
        burst(20); mark = cyc;
        gap(70);
        expect_det("wake_bounds", 0, 1, mark + 1);

        // Burst of 11 rejected.
        clear_det();
        send(11, 48); send(16, 48); send(16, 48);
        burst(16);
        gap(70);
        expect_det("burst11", 0, 0, 0);

        // Burst of 21 rejected.
        clear_det();
        send(21, 48); send(16, 48); send(16, 48);
        burst(16);
        gap(70);
        expect_det("burst21", 0, 0, 0);

        // Gap of 39 rejected; the following burst restarts the count.
        clear_det();
        send(16, 39); send(16, 48); send(16, 48);
        burst(16);
        gap(70);
        expect_det("gap39", 0, 0, 0);

        // Gap of 57 rejected (one past the init window).
        clear_det();
        send(16, 57); send(16, 48); send(16, 48);
        burst(16);
        gap(70);
        expect_det("gap57", 0, 0, 0);

        // Class switch: one init gap then wake gaps; wake detected after b5.
        clear_det();
        send(16, 48);
        for (int k = 0; k < 3; k++) send(16, 16);
        burst(16); mark = cyc;
        gap(70);
        expect_det("class_switch", 0, 1, mark + 1);

        // Reset after the third COMINIT burst discards progress.
        clear_det();
        for (int k = 0; k < 2; k++) send(16, 48);
        burst(16);
        gap(10);
        reset = 1'b1;
        step(1'b1);
        reset = 1'b0;
        gap(37);
        burst(16);
        gap(70);
        expect_det("mid_reset", 0, 0, 0);

        // A full sequence after the reset detects exactly once.
        clear_det();
        for (int k = 0; k < 3; k++) send(16, 48);
        burst(16); mark = cyc;
        gap(70);
        expect_det("post_reset", 1, 0, mark + 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
